// File: rtl/req_encoder.sv
// Registered N-source request encoder: latches request pulses into a pending
// bitmap and hands out one source index at a time over valid/ready.
module req_encoder #(
  parameter int  N    = 8,
  parameter int  MODE = 0,
  localparam int W    = (N > 1) ? $clog2(N) : 1,
  localparam int C    = $clog2(N + 1)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [N-1:0] i_req,
  input  logic         i_out_ready,
  output logic         o_out_valid,
  output logic [W-1:0] o_out_idx,
  output logic [C-1:0] o_pend_count
);

  logic [N-1:0] r_pend;
  logic         r_valid;
  logic [W-1:0] r_idx;

  logic         w_acc;
  logic         w_load;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_cand;
  logic [W-1:0] w_sel;

  assign w_acc  = r_valid & i_out_ready;
  assign w_load = ~r_valid | i_out_ready;

  always_comb begin
    w_clr = '0;
    if (w_acc) w_clr[r_idx] = 1'b1;
  end

  // Requests arriving this cycle are excluded so a grant always lags pend by one edge.
  assign w_cand = r_pend & ~w_clr;

  generate
    if (MODE == 0) begin : g_prio
      always_comb begin
        w_sel = '0;
        for (int i = 0; i < N; i++)
          if (w_cand[i]) w_sel = W'(i);
      end
    end else begin : g_rr
      logic [W-1:0] r_ptr;
      logic         w_hit_hi;
      logic [W-1:0] w_sel_hi;
      logic [W-1:0] w_sel_lo;

      // Downward scan leaves the lowest match in each variable: at/after ptr, and overall.
      always_comb begin
        w_hit_hi = 1'b0;
        w_sel_hi = '0;
        w_sel_lo = '0;
        for (int i = N - 1; i >= 0; i--) begin
          if (w_cand[i]) w_sel_lo = W'(i);
          if (w_cand[i] && (W'(i) >= r_ptr)) begin
            w_hit_hi = 1'b1;
            w_sel_hi = W'(i);
          end
        end
        w_sel = w_hit_hi ? w_sel_hi : w_sel_lo;
      end

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
          r_ptr <= '0;
        else if (w_acc)
          r_ptr <= (r_idx == W'(N - 1)) ? '0 : r_idx + 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | i_req;
      if (w_load) begin
        r_valid <= |w_cand;
        if (|w_cand) r_idx <= w_sel;
      end
    end
  end

  always_comb begin
    o_pend_count = '0;
    for (int i = 0; i < N; i++)
      o_pend_count = o_pend_count + C'(r_pend[i]);
  end

  assign o_out_valid = r_valid;
  assign o_out_idx   = r_idx;

endmodule

// File: tb/tb_req_encoder.sv
// Directed bench: three encoders (priority N=8, round-robin N=8, round-robin N=5).
module tb_req_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] a_req;  logic a_rdy, a_vld; logic [2:0] a_idx; logic [3:0] a_cnt;
  logic [7:0] b_req;  logic b_rdy, b_vld; logic [2:0] b_idx; logic [3:0] b_cnt;
  logic [4:0] c_req;  logic c_rdy, c_vld; logic [2:0] c_idx; logic [2:0] c_cnt;

  int total = 0;
  int bad   = 0;

  req_encoder #(.N(8), .MODE(0)) u_a (
    .i_clk(clk), .i_reset(rst), .i_req(a_req), .i_out_ready(a_rdy),
    .o_out_valid(a_vld), .o_out_idx(a_idx), .o_pend_count(a_cnt));
  req_encoder #(.N(8), .MODE(1)) u_b (
    .i_clk(clk), .i_reset(rst), .i_req(b_req), .i_out_ready(b_rdy),
    .o_out_valid(b_vld), .o_out_idx(b_idx), .o_pend_count(b_cnt));
  req_encoder #(.N(5), .MODE(1)) u_c (
    .i_clk(clk), .i_reset(rst), .i_req(c_req), .i_out_ready(c_rdy),
    .o_out_valid(c_vld), .o_out_idx(c_idx), .o_pend_count(c_cnt));

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; a_req = '0; b_req = '0; c_req = '0; a_rdy = 0; b_rdy = 0; c_rdy = 0;
    cyc(); cyc();
    total++; if ({a_vld, a_idx, a_cnt, b_vld, b_cnt, c_vld, c_cnt} !== 16'h0) begin
      bad++; $display("FAIL reset_init got=%h exp=0", {a_vld, a_idx, a_cnt, b_vld, b_cnt, c_vld, c_cnt}); end
    rst = 1'b0;
    a_req = 8'hA5;
    cyc(); a_req = '0;
    total++; if ({a_vld, a_cnt} !== {1'b0, 4'd4}) begin
      bad++; $display("FAIL rst_pend got=%h exp=04", {a_vld, a_cnt}); end
    cyc();
    total++; if ({a_vld, a_idx, a_cnt} !== {1'b1, 3'd7, 4'd4}) begin
      bad++; $display("FAIL rst_pre got=%h exp=%h", {a_vld, a_idx, a_cnt}, {1'b1, 3'd7, 4'd4}); end
    #2 rst = 1'b1;
    #1;
    total++; if ({a_vld, a_idx, a_cnt} !== 8'h0) begin
      bad++; $display("FAIL rst_async got=%h exp=0", {a_vld, a_idx, a_cnt}); end
    rst = 1'b0;
    a_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if ({a_vld, a_cnt} !== 5'h0) begin
        bad++; $display("FAIL rst_nogrant%0d got=%h exp=0", i, {a_vld, a_cnt}); end
    end
  endtask

  task automatic test_fixed_prio();
    a_rdy = 1'b1; a_req = 8'b1010_0000;
    cyc(); a_req = '0;
    total++; if ({a_vld, a_cnt} !== {1'b0, 4'd2}) begin
      bad++; $display("FAIL prio_lat got=%h exp=%h", {a_vld, a_cnt}, {1'b0, 4'd2}); end
    cyc();
    total++; if ({a_vld, a_idx, a_cnt} !== {1'b1, 3'd7, 4'd2}) begin
      bad++; $display("FAIL prio_7 got=%h exp=%h", {a_vld, a_idx, a_cnt}, {1'b1, 3'd7, 4'd2}); end
    cyc();
    total++; if ({a_vld, a_idx, a_cnt} !== {1'b1, 3'd5, 4'd1}) begin
      bad++; $display("FAIL prio_5 got=%h exp=%h", {a_vld, a_idx, a_cnt}, {1'b1, 3'd5, 4'd1}); end
    cyc();
    total++; if ({a_vld, a_idx, a_cnt} !== {1'b0, 3'd5, 4'd0}) begin
      bad++; $display("FAIL prio_idle got=%h exp=%h", {a_vld, a_idx, a_cnt}, {1'b0, 3'd5, 4'd0}); end
  endtask

  task automatic test_backpressure();
    a_rdy = 1'b0; a_req = 8'h04;
    cyc(); a_req = '0;
    cyc();
    total++; if ({a_vld, a_idx, a_cnt} !== {1'b1, 3'd2, 4'd1}) begin
      bad++; $display("FAIL bp_grant2 got=%h exp=%h", {a_vld, a_idx, a_cnt}, {1'b1, 3'd2, 4'd1}); end
    a_req = 8'h40;
    cyc(); a_req = '0;
    total++; if ({a_vld, a_idx, a_cnt} !== {1'b1, 3'd2, 4'd2}) begin
      bad++; $display("FAIL bp_hold1 got=%h exp=%h", {a_vld, a_idx, a_cnt}, {1'b1, 3'd2, 4'd2}); end
    cyc();
    total++; if ({a_vld, a_idx, a_cnt} !== {1'b1, 3'd2, 4'd2}) begin
      bad++; $display("FAIL bp_hold2 got=%h exp=%h", {a_vld, a_idx, a_cnt}, {1'b1, 3'd2, 4'd2}); end
    a_rdy = 1'b1;
    cyc();
    total++; if ({a_vld, a_idx, a_cnt} !== {1'b1, 3'd6, 4'd1}) begin
      bad++; $display("FAIL bp_grant6 got=%h exp=%h", {a_vld, a_idx, a_cnt}, {1'b1, 3'd6, 4'd1}); end
    cyc();
    total++; if ({a_vld, a_cnt} !== 5'h0) begin
      bad++; $display("FAIL bp_idle got=%h exp=0", {a_vld, a_cnt}); end
  endtask

  task automatic test_set_clear();
    a_rdy = 1'b1; a_req = 8'h08;
    cyc(); a_req = '0;
    cyc();
    total++; if ({a_vld, a_idx, a_cnt} !== {1'b1, 3'd3, 4'd1}) begin
      bad++; $display("FAIL sc_first got=%h exp=%h", {a_vld, a_idx, a_cnt}, {1'b1, 3'd3, 4'd1}); end
    a_req = 8'h08;
    cyc(); a_req = '0;
    total++; if ({a_vld, a_cnt} !== {1'b0, 4'd1}) begin
      bad++; $display("FAIL sc_bubble got=%h exp=%h", {a_vld, a_cnt}, {1'b0, 4'd1}); end
    cyc();
    total++; if ({a_vld, a_idx, a_cnt} !== {1'b1, 3'd3, 4'd1}) begin
      bad++; $display("FAIL sc_regrant got=%h exp=%h", {a_vld, a_idx, a_cnt}, {1'b1, 3'd3, 4'd1}); end
    for (int i = 0; i < 2; i++) begin
      cyc();
      total++; if ({a_vld, a_cnt} !== 5'h0) begin
        bad++; $display("FAIL sc_once%0d got=%h exp=0", i, {a_vld, a_cnt}); end
    end
  endtask

  task automatic test_rr8();
    b_rdy = 1'b1; b_req = 8'hFF;
    cyc(); b_req = '0;
    total++; if ({b_vld, b_cnt} !== {1'b0, 4'd8}) begin
      bad++; $display("FAIL rr8_lat got=%h exp=%h", {b_vld, b_cnt}, {1'b0, 4'd8}); end
    for (int i = 0; i < 8; i++) begin
      cyc();
      total++; if ({b_vld, b_idx, b_cnt} !== {1'b1, 3'(i), 4'(8 - i)}) begin
        bad++; $display("FAIL rr8_seq%0d got=%h exp=%h", i, {b_vld, b_idx, b_cnt}, {1'b1, 3'(i), 4'(8 - i)}); end
    end
    cyc();
    total++; if ({b_vld, b_cnt} !== 5'h0) begin
      bad++; $display("FAIL rr8_drain got=%h exp=0", {b_vld, b_cnt}); end
    b_req = 8'h81;
    cyc(); b_req = '0;
    cyc();
    total++; if ({b_vld, b_idx, b_cnt} !== {1'b1, 3'd0, 4'd2}) begin
      bad++; $display("FAIL rr8_wrap0 got=%h exp=%h", {b_vld, b_idx, b_cnt}, {1'b1, 3'd0, 4'd2}); end
    cyc();
    total++; if ({b_vld, b_idx, b_cnt} !== {1'b1, 3'd7, 4'd1}) begin
      bad++; $display("FAIL rr8_wrap7 got=%h exp=%h", {b_vld, b_idx, b_cnt}, {1'b1, 3'd7, 4'd1}); end
    cyc();
    // ptr now 0; grant 0 moves it to 1, so {0,1} must yield 1 first, then wrap to 0.
    b_req = 8'h01;
    cyc(); b_req = '0;
    cyc();
    cyc();
    b_req = 8'h03;
    cyc(); b_req = '0;
    cyc();
    total++; if ({b_vld, b_idx, b_cnt} !== {1'b1, 3'd1, 4'd2}) begin
      bad++; $display("FAIL rr8_ptr1 got=%h exp=%h", {b_vld, b_idx, b_cnt}, {1'b1, 3'd1, 4'd2}); end
    cyc();
    total++; if ({b_vld, b_idx, b_cnt} !== {1'b1, 3'd0, 4'd1}) begin
      bad++; $display("FAIL rr8_ptr0 got=%h exp=%h", {b_vld, b_idx, b_cnt}, {1'b1, 3'd0, 4'd1}); end
    cyc();
    total++; if ({b_vld, b_cnt} !== 5'h0) begin
      bad++; $display("FAIL rr8_end got=%h exp=0", {b_vld, b_cnt}); end
  endtask

  task automatic test_rr5();
    c_rdy = 1'b1; c_req = 5'b10000;
    cyc(); c_req = '0;
    cyc();
    total++; if ({c_vld, c_idx, c_cnt} !== {1'b1, 3'd4, 3'd1}) begin
      bad++; $display("FAIL rr5_idx4 got=%h exp=%h", {c_vld, c_idx, c_cnt}, {1'b1, 3'd4, 3'd1}); end
    cyc();
    total++; if ({c_vld, c_cnt} !== 4'h0) begin
      bad++; $display("FAIL rr5_drain got=%h exp=0", {c_vld, c_cnt}); end
    c_req = 5'b10001;
    cyc(); c_req = '0;
    cyc();
    total++; if ({c_vld, c_idx, c_cnt} !== {1'b1, 3'd0, 3'd2}) begin
      bad++; $display("FAIL rr5_first0 got=%h exp=%h", {c_vld, c_idx, c_cnt}, {1'b1, 3'd0, 3'd2}); end
    cyc();
    total++; if ({c_vld, c_idx, c_cnt} !== {1'b1, 3'd4, 3'd1}) begin
      bad++; $display("FAIL rr5_then4 got=%h exp=%h", {c_vld, c_idx, c_cnt}, {1'b1, 3'd4, 3'd1}); end
    cyc();
    total++; if ({c_vld, c_cnt} !== 4'h0) begin
      bad++; $display("FAIL rr5_end got=%h exp=0", {c_vld, c_cnt}); end
  endtask

  initial begin
    test_reset();
    test_fixed_prio();
    test_backpressure();
    test_set_clear();
    test_rr8();
    test_rr5();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
